// File: rtl/gdiv_pkg.sv
// Shared constants and the tracking-pipe entry for the Goldschmidt divider stream controller.
package gdiv_pkg;

  localparam int unsigned DIV_W   = 16;
  localparam int unsigned DIV_LAT = 17;
  localparam int unsigned TAG_W   = 4;

  localparam logic [DIV_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [DIV_W-1:0] SAT_NEG = 16'h8000;

  typedef struct packed {
    logic             v;
    logic             dz;
    logic             nsign;
    logic [TAG_W-1:0] tag;
  } pipe_ent_t;

  // Divide-by-zero result saturates toward the sign of the dividend.
  function automatic logic [DIV_W-1:0] sat_quot(input logic nsign);
    return nsign ? SAT_NEG : SAT_POS;
  endfunction

endpackage

// File: rtl/gdiv_stream_ctrl_if.sv
// Operand/result handshake bundle for gdiv_stream_ctrl.
interface gdiv_stream_ctrl_if #(
  parameter int unsigned TAGW = 4
);
  import gdiv_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [DIV_W-1:0] in_n;
  logic [DIV_W-1:0] in_d;
  logic [TAGW-1:0]  in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [DIV_W-1:0] out_q;
  logic [TAGW-1:0]  out_tag;
  logic             out_dz;

  modport master (
    output in_valid, in_n, in_d, in_tag, out_ready,
    input  in_ready, out_valid, out_q, out_tag, out_dz
  );

  modport slave (
    input  in_valid, in_n, in_d, in_tag, out_ready,
    output in_ready, out_valid, out_q, out_tag, out_dz
  );

endinterface

// File: rtl/gdiv_res_fifo.sv
// Circular result buffer with wrapping pointers; simultaneous push and pop allowed even when full.
module gdiv_res_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 21
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push_i) wr_d = ptr_next(wr_q);
    if (pop_i)  rd_d = ptr_next(rd_q);
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  // Storage is not reset; masking keeps the head at zero whenever nothing is held.
  assign rdata_o = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/gdiv_stream_ctrl.sv
// Credit-based issue/capture controller around a free-running fixed-latency divider pipeline.
module gdiv_stream_ctrl
  import gdiv_pkg::*;
#(
  parameter int unsigned LAT   = DIV_LAT,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAGW  = TAG_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DIV_W-1:0]           in_n,
  input  logic [DIV_W-1:0]           in_d,
  input  logic [TAGW-1:0]            in_tag,
  output logic [DIV_W-1:0]           div_n,
  output logic [DIV_W-1:0]           div_d,
  input  logic [DIV_W-1:0]           div_q,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DIV_W-1:0]           out_q,
  output logic [TAGW-1:0]            out_tag,
  output logic                       out_dz,
  output logic [$clog2(DEPTH+1)-1:0] inflight
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned EW = DIV_W + 1 + TAGW;
  localparam logic [CW:0] CREDITS = DEPTH[CW:0];

  if (TAGW != TAG_W) begin : g_tagw_chk
    $error("gdiv_stream_ctrl: TAGW must match gdiv_pkg::TAG_W");
  end

  logic             accept, capture, pop;
  logic             ready_en_q;
  logic [DIV_W-1:0] div_n_q, div_d_q;
  pipe_ent_t        pipe_q [LAT+1];
  pipe_ent_t        stage0_d;
  pipe_ent_t        tail;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full, fifo_empty;
  logic [DIV_W-1:0] cap_quot;
  logic [EW-1:0]    fifo_wdata, fifo_rdata;

  assign accept  = in_valid && in_ready;
  assign tail    = pipe_q[LAT];
  assign capture = tail.v;
  assign pop     = out_valid && out_ready;

  // Credits come only from registered counters, so a pop frees a slot one cycle later.
  assign in_ready = ready_en_q &&
                    (({1'b0, fifo_count} + {1'b0, inflight_q}) < CREDITS);

  always_comb begin
    stage0_d       = '0;
    stage0_d.v     = accept;
    stage0_d.dz    = (in_d == '0);
    stage0_d.nsign = in_n[DIV_W-1];
    stage0_d.tag   = in_tag;
  end

  always_comb begin
    inflight_d = inflight_q;
    unique case ({accept, capture})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en_q <= 1'b0;
      div_n_q    <= '0;
      div_d_q    <= '0;
      inflight_q <= '0;
      for (int unsigned i = 0; i <= LAT; i++) pipe_q[i] <= '0;
    end else begin
      ready_en_q <= 1'b1;
      inflight_q <= inflight_d;
      if (accept) begin
        div_n_q <= in_n;
        div_d_q <= in_d;
      end
      pipe_q[0] <= stage0_d;
      for (int unsigned i = 1; i <= LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign cap_quot   = tail.dz ? sat_quot(tail.nsign) : div_q;
  assign fifo_wdata = {cap_quot, tail.dz, tail.tag};

  gdiv_res_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (capture),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {out_q, out_dz, out_tag} = fifo_rdata;
  assign out_valid = !fifo_empty;
  assign div_n     = div_n_q;
  assign div_d     = div_d_q;
  assign inflight  = inflight_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(capture && fifo_full && !pop));

  a_out_stable: assert property (@(posedge clk) disable iff (!reset)
    (out_valid && !out_ready) |=> $stable({out_q, out_tag, out_dz}));

endmodule

// File: tb/tb_gdiv_stream_ctrl.sv
// Scoreboard bench for gdiv_stream_ctrl with a pure-delay stand-in for the divider.
module tb_gdiv_stream_ctrl;
  import gdiv_pkg::*;

  localparam int unsigned LAT   = 17;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAGW  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] div_n, div_d, div_q;
  logic [2:0]  inflight;

  gdiv_stream_ctrl_if #(.TAGW(TAGW)) bus ();

  gdiv_stream_ctrl #(
    .LAT   (LAT),
    .DEPTH (DEPTH),
    .TAGW  (TAGW)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_n      (bus.in_n),
    .in_d      (bus.in_d),
    .in_tag    (bus.in_tag),
    .div_n     (div_n),
    .div_d     (div_d),
    .div_q     (div_q),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_q     (bus.out_q),
    .out_tag   (bus.out_tag),
    .out_dz    (bus.out_dz),
    .inflight  (inflight)
  );

  always #5 clk = ~clk;

  // Divider stand-in: quotient equals the dividend, LAT edges after it was driven.
  logic [15:0] dsr [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) dsr[i] <= '0;
    end else begin
      dsr[0] <= div_n;
      for (int i = 1; i < LAT; i++) dsr[i] <= dsr[i-1];
    end
  end
  assign div_q = dsr[LAT-1];

  typedef struct packed {
    logic [15:0]     q;
    logic [TAGW-1:0] tag;
    logic            dz;
  } exp_t;

  exp_t sbq [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got q=%h tag=%h dz=%b, required no result (t=%0t)",
                 bus.out_q, bus.out_tag, bus.out_dz, $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_q", bus.out_q, e.q);
        chk("out_tag", bus.out_tag, e.tag);
        chk("out_dz", bus.out_dz, e.dz);
      end
    end
  end

  // Offer one operation and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic send(input logic [15:0] n, input logic [15:0] d, input logic [TAGW-1:0] tag,
                      input logic [15:0] eq, input logic edz);
    bit done = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_n     = n;
    bus.in_d     = d;
    bus.in_tag   = tag;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sbq.push_back(exp_t'{eq, tag, edz});
        done = 1;
      end
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    logic [TAGW-1:0] tagcnt;
    bit pending;

    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_n      = '0;
    bus.in_d      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_out_q", bus.out_q, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_out_dz", bus.out_dz, 0);
    chk("rst_div_n", div_n, 0);
    chk("rst_div_d", div_d, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", bus.in_ready, 1);

    // Single operation: 18-edge latency
    bus.out_ready = 1'b1;
    send(16'h0123, 16'h0040, 4'd3, 16'h0123, 1'b0);
    chk("single_div_n", div_n, 16'h0123);
    chk("single_div_d", div_d, 16'h0040);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      chk("single_inflight", inflight, 1);
      if (k == 17) chk("single_valid_early", bus.out_valid, 0);
    end
    @(negedge clk);
    chk("single_out_valid", bus.out_valid, 1);
    chk("single_inflight_done", inflight, 0);
    repeat (3) @(posedge clk);
    #1 chk("single_drained", sbq.size(), 0);

    // Back-pressure: 6 offered, 4 credits
    bus.out_ready = 1'b0;
    acc = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_n     = 16'h1000;
    bus.in_d     = 16'h0001;
    bus.in_tag   = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        sbq.push_back(exp_t'{16'(16'h1000 + acc), TAGW'(acc), 1'b0});
        acc++;
      end
      @(posedge clk); #1;
      if (acc < 6) begin
        bus.in_n   = 16'(16'h1000 + acc);
        bus.in_tag = TAGW'(acc);
      end
    end
    bus.in_valid = 1'b0;
    chk("bp_accepted", acc, 4);
    @(negedge clk);
    chk("bp_in_ready_low", bus.in_ready, 0);
    chk("bp_inflight_zero", inflight, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_before_pop", bus.in_ready, 0);
    @(negedge clk);
    chk("bp_ready_after_pop", bus.in_ready, 1);
    repeat (8) @(posedge clk);
    #1 chk("bp_drained", sbq.size(), 0);

    // Zero divisor saturation
    send(16'h8123, 16'h0000, 4'd5, 16'h8000, 1'b1);
    send(16'h0005, 16'h0000, 4'd6, 16'h7FFF, 1'b1);
    repeat (25) @(posedge clk);
    #1 chk("dz_drained", sbq.size(), 0);

    // Capture and pop on the same edge with all credits in use
    bus.out_ready = 1'b0;
    send(16'h0A01, 16'h0003, 4'd1, 16'h0A01, 1'b0);
    send(16'h0A02, 16'hFFFF, 4'd2, 16'h0A02, 1'b0);
    send(16'hFA03, 16'h0007, 4'd3, 16'hFA03, 1'b0);
    repeat (22) @(posedge clk);
    send(16'h0A04, 16'h0100, 4'd4, 16'h0A04, 1'b0);
    repeat (17) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    chk("sim_pre_inflight", inflight, 1);
    chk("sim_pre_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("sim_post_inflight", inflight, 0);
    chk("sim_post_in_ready", bus.in_ready, 1);
    chk("sim_post_out_valid", bus.out_valid, 1);
    chk("sim_post_head_tag", bus.out_tag, 2);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("sim_drained", sbq.size(), 0);
    chk("sim_empty", bus.out_valid, 0);

    // Reset with two results buffered and two in flight
    bus.out_ready = 1'b0;
    send(16'h0B01, 16'h0001, 4'd7, 16'h0B01, 1'b0);
    send(16'h0B02, 16'h0001, 4'd8, 16'h0B02, 1'b0);
    repeat (20) @(posedge clk);
    send(16'h0B03, 16'h0001, 4'd9, 16'h0B03, 1'b0);
    send(16'h0B04, 16'h0001, 4'd10, 16'h0B04, 1'b0);
    @(negedge clk);
    chk("mr_pre_inflight", inflight, 2);
    chk("mr_pre_out_valid", bus.out_valid, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mr_in_ready", bus.in_ready, 0);
    chk("mr_out_valid", bus.out_valid, 0);
    chk("mr_inflight", inflight, 0);
    chk("mr_out_q", bus.out_q, 0);
    chk("mr_out_tag", bus.out_tag, 0);
    chk("mr_out_dz", bus.out_dz, 0);
    chk("mr_div_n", div_n, 0);
    chk("mr_div_d", div_d, 0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk("mr_no_stale", bus.out_valid, 0);
    end
    chk("mr_ready_back", bus.in_ready, 1);

    // Random stress
    tagcnt  = '0;
    pending = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        sbq.push_back(exp_t'{(bus.in_d == 16'h0000) ? sat_quot(bus.in_n[15]) : bus.in_n,
                             bus.in_tag, (bus.in_d == 16'h0000)});
        pending = 0;
        tagcnt  = tagcnt + 1'b1;
      end
      @(posedge clk); #1;
      if (!pending && $urandom_range(0, 2) != 0) begin
        bus.in_n   = 16'($urandom);
        bus.in_d   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
        bus.in_tag = tagcnt;
        pending    = 1;
      end
      bus.in_valid  = pending;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 100 && sbq.size() != 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("stress_drained", sbq.size(), 0);
    chk("stress_out_valid", bus.out_valid, 0);
    chk("stress_inflight", inflight, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
